// File: rtl/bram_stream_reader.sv
// Purpose: streams a burst of 64-bit words from a block RAM onto a valid/ready output stream.
// Latency: first m_valid two cycles after busy rises; one beat per cycle when m_ready is held high.
// Backpressure: m_ready low stops RAM reads once the 2-entry output buffer plus in-flight read is full.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   start, base_addr, len    burst request (byte address, 64-bit word count), sampled in IDLE only
//   busy, done               busy while a burst runs; done pulses with the final handshake
//                            (or one cycle after a zero-length start)
//   bram_raddr, bram_rdata   RAM read port, data valid one clk after the address is sampled
//   m_valid, m_ready,
//   m_data, m_last           output stream; m_last marks the final beat of the burst

// Small synchronous FIFO with simultaneous push/pop and an occupancy count.
// Head data is presented combinationally from storage; push into a full FIFO
// is only honoured when a pop frees a slot in the same cycle.
module bram_stream_reader_fifo #(
  parameter  int W     = 64,
  parameter  int DEPTH = 2,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head_dat,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop   = pop && (count != '0);
  assign do_push  = push && ((count != CW'(DEPTH)) || do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      // Storage is cleared too so the head reads as zero after reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

module bram_stream_reader #(
  parameter int ADDR_STEP = 8,
  parameter int LEN_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [31:0]      bram_raddr,
  input  logic [63:0]      bram_rdata,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [63:0]      m_data,
  output logic             m_last
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [31:0]      addr_q;      // next RAM read address
  logic [LEN_W-1:0] rem_q;       // reads still to issue
  logic [LEN_W-1:0] len_q;       // burst length latched at start
  logic [LEN_W-1:0] beats_q;     // beats already handed downstream
  logic             inflight_q;  // a read was issued last cycle; its data is on bram_rdata now
  logic             zero_done_q; // zero-length request completes one cycle after start

  logic       pop;
  logic       last_hs;
  logic       issue;
  logic [1:0] fifo_count;
  logic [2:0] occ;

  assign pop     = m_valid && m_ready;
  assign last_hs = pop && m_last;

  // Slots committed after this cycle: buffered + arriving - leaving. A read is
  // only issued when that leaves room for its data next cycle, so the FIFO
  // can never overflow even if m_ready drops.
  assign occ   = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue = (state == RUN) && (rem_q != '0) && (occ < 3'd2);

  bram_stream_reader_fifo #(
    .W     (64),
    .DEPTH (2)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight_q),
    .push_dat (bram_rdata),
    .pop      (pop),
    .head_dat (m_data),
    .count    (fifo_count)
  );

  assign m_valid    = (fifo_count != '0);
  assign bram_raddr = addr_q;
  assign busy       = (state == RUN);
  // Beat counter only moves on a handshake, so m_last is stable while stalled.
  assign m_last     = m_valid && (state == RUN) && (beats_q == len_q - LEN_W'(1));
  assign done       = zero_done_q || ((state == RUN) && last_hs);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      len_q       <= '0;
      beats_q     <= '0;
      inflight_q  <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      zero_done_q <= 1'b0;
      inflight_q  <= issue;
      case (state)
        IDLE: begin
          if (start) begin
            if (len == '0) begin
              // Nothing to read: leave the address counter untouched.
              zero_done_q <= 1'b1;
            end else begin
              state   <= RUN;
              addr_q  <= base_addr;
              rem_q   <= len;
              len_q   <= len;
              beats_q <= '0;
            end
          end
        end
        RUN: begin
          if (issue) begin
            addr_q <= addr_q + 32'(ADDR_STEP);
            rem_q  <= rem_q - LEN_W'(1);
          end
          if (pop) begin
            beats_q <= beats_q + LEN_W'(1);
          end
          if (last_hs) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
module tb_bram_stream_reader;

  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [31:0]      base_addr;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             done;
  logic [31:0]      bram_raddr;
  logic [63:0]      bram_rdata = '0;
  logic             m_valid;
  logic             m_ready;
  logic [63:0]      m_data;
  logic             m_last;

  typedef struct {
    logic [63:0] dat;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks   = 0;
  int    n_fail     = 0;
  int    beats_seen = 0;
  int    done_cnt   = 0;

  bram_stream_reader #(
    .ADDR_STEP (8),
    .LEN_W     (LEN_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .bram_raddr (bram_raddr),
    .bram_rdata (bram_rdata),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ram_word(input logic [31:0] a);
    return {~a, a ^ 32'h5A5A_1234};
  endfunction

  // Synchronous-read RAM model: data for the address sampled at an edge is
  // visible for the whole following cycle.
  always @(posedge clk) bram_rdata <= ram_word(bram_raddr);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every handshake must match the next expected word and last flag.
  always @(negedge clk) begin
    if (!rst && done) done_cnt++;
    if (!rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {63'd0, m_valid}, 64'd0);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check("beat_data", m_data, e.dat);
        check("beat_last", {63'd0, m_last}, {63'd0, e.last});
      end
      beats_seen++;
    end
  end

  // Call at posedge+1; returns at posedge+1 of the first busy cycle.
  task automatic start_burst(input logic [31:0] b, input logic [LEN_W-1:0] n);
    start     = 1'b1;
    base_addr = b;
    len       = n;
    for (int i = 0; i < int'(n); i++) begin
      exp_q.push_back('{dat: ram_word(b + 32'(i * 8)), last: (i == int'(n) - 1)});
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    check(tag, {63'd0, seen}, 64'd1);
  endtask

  task automatic wait_valid(input int max_cyc, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      seen = m_valid;
    end
    check(tag, {63'd0, seen}, 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},   {63'd0, busy},    64'd0);
    check({tag, "_done"},   {63'd0, done},    64'd0);
    check({tag, "_valid"},  {63'd0, m_valid}, 64'd0);
    check({tag, "_last"},   {63'd0, m_last},  64'd0);
    check({tag, "_data"},   m_data,           64'd0);
    check({tag, "_raddr"},  {32'd0, bram_raddr}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    int d0;
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    len       = '0;
    m_ready   = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst     = 1'b0;
    m_ready = 1'b1;

    // Basic burst: consecutive addresses, back-to-back beats, last+done together
    start_burst(32'h0000_0100, 16'd4);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k < 4) check("t1_raddr", {32'd0, bram_raddr}, {32'd0, 32'h100 + 32'(k * 8)});
      check("t1_busy",  {63'd0, busy},    64'd1);
      check("t1_valid", {63'd0, m_valid}, {63'd0, k >= 2});
      check("t1_done",  {63'd0, done},    {63'd0, k == 5});
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("t1_busy_fall", {63'd0, busy}, 64'd0);
    check("t1_done_off",  {63'd0, done}, 64'd0);
    check("t1_q_empty",   64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;

    // Backpressure: data frozen, reads capped at two ahead of delivery
    b0      = beats_seen;
    m_ready = 1'b0;
    start_burst(32'h0000_2000, 16'd6);
    wait_valid(10, "t2_valid_timeout");
    for (int i = 0; i < 5; i++) begin
      check("t2_stall_valid", {63'd0, m_valid}, 64'd1);
      check("t2_stall_data",  m_data, ram_word(32'h2000));
      check("t2_stall_last",  {63'd0, m_last}, 64'd0);
      check("t2_stall_raddr", {32'd0, bram_raddr}, {32'd0, 32'h2010});
      @(posedge clk); #1;
      if (i == 4) m_ready = 1'b1;
      else        @(negedge clk);
    end
    wait_done(30, "t2_done_timeout");
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t2_beats",   64'(beats_seen - b0), 64'd6);
    check("t2_q_empty", 64'(exp_q.size()),    64'd0);

    // Zero-length request
    start     = 1'b1;
    base_addr = 32'h0000_7000;
    len       = '0;
    @(negedge clk);
    check("t3_done_c0", {63'd0, done}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("t3_done_c1",  {63'd0, done},    64'd1);
    check("t3_busy_c1",  {63'd0, busy},    64'd0);
    check("t3_valid_c1", {63'd0, m_valid}, 64'd0);
    check("t3_raddr_c1", {32'd0, bram_raddr}, {32'd0, 32'h2030});
    @(posedge clk); #1;
    @(negedge clk);
    check("t3_done_c2",  {63'd0, done}, 64'd0);
    check("t3_busy_c2",  {63'd0, busy}, 64'd0);
    check("t3_raddr_c2", {32'd0, bram_raddr}, {32'd0, 32'h2030});
    @(posedge clk); #1;

    // Address wrap at 2^32
    start_burst(32'hFFFF_FFF8, 16'd2);
    @(negedge clk);
    check("t4_raddr0", {32'd0, bram_raddr}, {32'd0, 32'hFFFF_FFF8});
    @(posedge clk); #1;
    @(negedge clk);
    check("t4_raddr1", {32'd0, bram_raddr}, 64'd0);
    wait_done(20, "t4_done_timeout");
    @(posedge clk); #1;

    // Start during RUN is ignored
    b0 = beats_seen;
    d0 = done_cnt;
    start_burst(32'h0000_3000, 16'd3);
    start     = 1'b1;
    base_addr = 32'h0000_4000;
    len       = 16'd5;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(20, "t5_done_timeout");
    repeat (4) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("t5_beats",   64'(beats_seen - b0), 64'd3);
    check("t5_dones",   64'(done_cnt - d0),   64'd1);
    check("t5_q_empty", 64'(exp_q.size()),    64'd0);
    check("t5_raddr",   {32'd0, bram_raddr},  {32'd0, 32'h3018});
    check("t5_busy",    {63'd0, busy},        64'd0);
    @(posedge clk); #1;

    // Reset mid-burst after the second beat
    b0 = beats_seen;
    start_burst(32'h0000_5000, 16'd8);
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst     = 1'b1;
    m_ready = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst     = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    check("t6_beats_before", 64'(beats_seen - b0), 64'd2);
    check_reset_outputs("t6_after_rst");
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("t6_no_beat", {63'd0, m_valid}, 64'd0);
    end
    @(posedge clk); #1;

    // Normal operation after reset
    b0 = beats_seen;
    d0 = done_cnt;
    start_burst(32'h0000_0600, 16'd1);
    @(negedge clk);
    check("t7_raddr", {32'd0, bram_raddr}, {32'd0, 32'h600});
    wait_done(20, "t7_done_timeout");
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t7_beats",   64'(beats_seen - b0), 64'd1);
    check("t7_dones",   64'(done_cnt - d0),   64'd1);
    check("t7_q_empty", 64'(exp_q.size()),    64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
